vend_timer_ctrl: RTL and testbench

- Consumer side of the vending-machine time generator.
- Drives the generator's en/set controls and consumes its half_second/second/three_seconds/five_seconds tick levels.
- Sequences the purchase flow: coin-collection inactivity timeout, refund hold, dispense-motor window and "thank you" message hold.
- Sits between the coin/selection front end and the actuator/display outputs.

---
 rtl/vend_pkg.sv | 22 ++
 rtl/tick_edge_qual.sv | 45 ++++
 rtl/vend_timer_ctrl.sv | 147 ++++++++++++++
 tb/tb_vend_timer_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared constants for the vending-machine timer controller:
// state encoding, default timing parameters and counter widths.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    DISPENSE = 3'd2,
    MSG      = 3'd3,
    REFUND   = 3'd4
  } state_t;

  localparam int SET_MASK_DEF      = 2;
  localparam int REFUND_HALVES_DEF = 2;
  localparam int MSG_HALVES_DEF    = 4;

  localparam int MASK_W  = 4;
  localparam int HALF_W  = 4;
  localparam int SEC_W   = 2;
  localparam int TOCNT_W = 8;

endpackage

// File: rtl/tick_edge_qual.sv
// Registers the four generator tick levels and emits qualified rise
// strobes, suppressed for SET_MASK cycles after each generator restart.
// Ports: clk, rst, set (restart pulse), tick_* levels in, rise_* out.
module tick_edge_qual
  import vend_pkg::*;
#(
  parameter int SET_MASK = SET_MASK_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic tick_half,
  input  logic tick_1s,
  input  logic tick_3s,
  input  logic tick_5s,
  output logic rise_half,
  output logic rise_1s,
  output logic rise_3s,
  output logic rise_5s
);

  logic [3:0]        tick_q;
  logic [MASK_W-1:0] mask;
  logic              quiet;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
      mask   <= '0;
    end else begin
      tick_q <= {tick_5s, tick_3s, tick_1s, tick_half};
      if (set)
        mask <= MASK_W'(SET_MASK);
      else if (mask != '0)
        mask <= mask - 1'b1;
    end
  end

  assign quiet     = (mask == '0);
  assign rise_half = tick_half & ~tick_q[0] & quiet;
  assign rise_1s   = tick_1s   & ~tick_q[1] & quiet;
  assign rise_3s   = tick_3s   & ~tick_q[2] & quiet;
  assign rise_5s   = tick_5s   & ~tick_q[3] & quiet;

endmodule

// File: rtl/vend_timer_ctrl.sv
// Purchase-flow sequencer driving the time generator (coin timeout,
// refund hold, dispense window, thank-you message). Ports: clk, rst,
// coin_evt/vend_req/cancel pulses, tick_* levels; outputs tg_en, tg_set,
// motor_on, refund, msg_show, coin_reject, busy, state_o.
// Option VEND_TIMER_TIMEOUT_CNT_EN adds timeout_cnt and a 3 s refund guard.
module vend_timer_ctrl
  import vend_pkg::*;
#(
  parameter int SET_MASK      = SET_MASK_DEF,
  parameter int REFUND_HALVES = REFUND_HALVES_DEF,
  parameter int MSG_HALVES    = MSG_HALVES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_evt,
  input  logic       vend_req,
  input  logic       cancel,
  input  logic       tick_half,
  input  logic       tick_1s,
  input  logic       tick_3s,
  input  logic       tick_5s,
  output logic       tg_en,
  output logic       tg_set,
  output logic       motor_on,
  output logic       refund,
  output logic       msg_show,
  output logic       coin_reject,
  output logic       busy,
  output logic [2:0] state_o
`ifdef VEND_TIMER_TIMEOUT_CNT_EN
  ,
  output logic [TOCNT_W-1:0] timeout_cnt
`endif
);

  state_t            state, nxt;
  logic [HALF_W-1:0] half_cnt;
  logic              restart, entry;
  logic              rise_half, rise_1s, rise_3s, rise_5s;

  tick_edge_qual #(
    .SET_MASK(SET_MASK)
  ) u_qual (
    .clk      (clk),
    .rst      (rst),
    .set      (tg_set),
    .tick_half(tick_half),
    .tick_1s  (tick_1s),
    .tick_3s  (tick_3s),
    .tick_5s  (tick_5s),
    .rise_half(rise_half),
    .rise_1s  (rise_1s),
    .rise_3s  (rise_3s),
    .rise_5s  (rise_5s)
  );

`ifdef VEND_TIMER_TIMEOUT_CNT_EN
  logic [SEC_W-1:0] sec_cnt;
  logic             to_hit;
`else
  logic             unused_rise_1s;
  assign unused_rise_1s = rise_1s;
`endif

  always_comb begin
    nxt     = state;
    restart = 1'b0;
    unique case (state)
      IDLE:
        if (coin_evt) nxt = COLLECT;
      COLLECT:
        if (cancel)        nxt = REFUND;
        else if (vend_req) nxt = DISPENSE;
        else if (coin_evt) restart = 1'b1;
        else if (rise_5s)  nxt = REFUND;
      DISPENSE:
        if (rise_3s) nxt = MSG;
      MSG:
        if (rise_half &&
            half_cnt == HALF_W'(MSG_HALVES - 1))
          nxt = IDLE;
      REFUND:
        if (rise_half &&
            half_cnt == HALF_W'(REFUND_HALVES - 1))
          nxt = IDLE;
`ifdef VEND_TIMER_TIMEOUT_CNT_EN
        else if (rise_1s && sec_cnt == SEC_W'(2))
          nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
  end

  assign entry   = (nxt != state);
  assign state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tg_set      <= 1'b0;
      tg_en       <= 1'b0;
      busy        <= 1'b0;
      motor_on    <= 1'b0;
      refund      <= 1'b0;
      msg_show    <= 1'b0;
      coin_reject <= 1'b0;
      half_cnt    <= '0;
    end else begin
      state       <= nxt;
      tg_set      <= (entry && nxt != IDLE) || restart;
      tg_en       <= (nxt != IDLE);
      busy        <= (nxt != IDLE);
      motor_on    <= (nxt == DISPENSE);
      refund      <= (nxt == REFUND);
      msg_show    <= (nxt == MSG);
      coin_reject <= coin_evt &&
                     (state == DISPENSE ||
                      state == MSG ||
                      state == REFUND);
      if (entry)
        half_cnt <= '0;
      else if (rise_half)
        half_cnt <= half_cnt + 1'b1;
    end
  end

`ifdef VEND_TIMER_TIMEOUT_CNT_EN
  // Only a plain inactivity timeout counts; cancel has priority.
  assign to_hit = (state == COLLECT) && (nxt == REFUND) &&
                  !cancel && !vend_req && !coin_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt     <= '0;
      timeout_cnt <= '0;
    end else begin
      if (entry)
        sec_cnt <= '0;
      else if (rise_1s && sec_cnt != '1)
        sec_cnt <= sec_cnt + 1'b1;
      if (to_hit && timeout_cnt != '1)
        timeout_cnt <= timeout_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vend_timer_ctrl.sv
// Directed self-checking bench for vend_timer_ctrl.
// Inputs change 1 ns after posedge; outputs are sampled there too.
module tb_vend_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_evt, vend_req, cancel;
  logic       tick_half, tick_1s, tick_3s, tick_5s;
  logic       tg_en, tg_set, motor_on, refund;
  logic       msg_show, coin_reject, busy;
  logic [2:0] state_o;
`ifdef VEND_TIMER_TIMEOUT_CNT_EN
  logic [7:0] timeout_cnt;
`endif

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  vend_timer_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .coin_evt   (coin_evt),
    .vend_req   (vend_req),
    .cancel     (cancel),
    .tick_half  (tick_half),
    .tick_1s    (tick_1s),
    .tick_3s    (tick_3s),
    .tick_5s    (tick_5s),
    .tg_en      (tg_en),
    .tg_set     (tg_set),
    .motor_on   (motor_on),
    .refund     (refund),
    .msg_show   (msg_show),
    .coin_reject(coin_reject),
    .busy       (busy),
    .state_o    (state_o)
`ifdef VEND_TIMER_TIMEOUT_CNT_EN
    ,
    .timeout_cnt(timeout_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic coin();
    coin_evt = 1'b1;
    cyc();
    coin_evt = 1'b0;
  endtask

  task automatic half_rise();
    tick_half = 1'b1;
    cyc();
    tick_half = 1'b0;
    cyc();
  endtask

  task automatic sec_rise();
    tick_1s = 1'b1;
    cyc();
    tick_1s = 1'b0;
    cyc();
  endtask

  task automatic timeout_seq();
    coin();
    idle(4);
    tick_5s = 1'b1;
    cyc();
    tick_5s = 1'b0;
    idle(4);
  endtask

  initial begin
    rst = 1'b1;
    coin_evt = 0; vend_req = 0; cancel = 0;
    tick_half = 0; tick_1s = 0; tick_3s = 0; tick_5s = 0;
    #2;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_outs", 32'({tg_en, tg_set, motor_on,
                         refund, msg_show, coin_reject}), 0);
    cyc();
    rst = 1'b0;
    idle(2);

    vend_req = 1; cancel = 1;
    cyc();
    vend_req = 0; cancel = 0;
    chk("idle_ignore", 32'(state_o), 0);
    chk("idle_busy", 32'(busy), 0);

    coin();
    chk("to_collect", 32'(state_o), 1);
    chk("to_tgset", 32'(tg_set), 1);
    chk("to_tgen", 32'(tg_en), 1);
    cyc();
    chk("to_tgset_1cyc", 32'(tg_set), 0);
    idle(8);
    chk("to_wait", 32'(state_o), 1);
    tick_5s = 1'b1;
    cyc();
    tick_5s = 1'b0;
    chk("to_refund_st", 32'(state_o), 4);
    chk("to_refund", 32'(refund), 1);
    chk("to_refund_set", 32'(tg_set), 1);
    idle(4);
    half_rise();
    chk("to_hold", 32'(refund), 1);
    half_rise();
    chk("to_release", 32'(refund), 0);
    chk("to_idle", 32'(state_o), 0);
    chk("to_tgen_off", 32'(tg_en), 0);

    coin();
    idle(4);
    vend_req = 1'b1;
    cyc();
    vend_req = 1'b0;
    chk("pu_disp", 32'(state_o), 2);
    chk("pu_motor", 32'(motor_on), 1);
    chk("pu_tgset", 32'(tg_set), 1);
    idle(4);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    chk("pu_cancel_ign", 32'(state_o), 2);
    coin();
    chk("rej_pulse", 32'(coin_reject), 1);
    chk("rej_motor", 32'(motor_on), 1);
    chk("rej_state", 32'(state_o), 2);
    cyc();
    chk("rej_1cyc", 32'(coin_reject), 0);
    chk("rej_motor2", 32'(motor_on), 1);
    tick_3s = 1'b1;
    cyc();
    tick_3s = 1'b0;
    chk("pu_msg_st", 32'(state_o), 3);
    chk("pu_motor_off", 32'(motor_on), 0);
    chk("pu_msg", 32'(msg_show), 1);
    idle(4);
    for (int i = 1; i <= 3; i++) begin
      half_rise();
      chk($sformatf("pu_msg_hold%0d", i),
          32'(msg_show), 1);
    end
    half_rise();
    chk("pu_msg_off", 32'(msg_show), 0);
    chk("pu_idle", 32'(state_o), 0);

    coin();
    idle(4);
    cancel = 1; vend_req = 1;
    cyc();
    cancel = 0; vend_req = 0;
    chk("pri_state", 32'(state_o), 4);
    chk("pri_motor", 32'(motor_on), 0);
    idle(4);
    half_rise();
    half_rise();
    chk("pri_idle", 32'(state_o), 0);

    coin();
    idle(4);
    coin();
    chk("mask_tgset", 32'(tg_set), 1);
    cyc();
    tick_5s = 1'b1;
    cyc();
    tick_5s = 1'b0;
    chk("mask_ignored", 32'(state_o), 1);
    idle(4);
    tick_5s = 1'b1;
    cyc();
    tick_5s = 1'b0;
    chk("mask_after", 32'(state_o), 4);
    idle(4);
    half_rise();
    half_rise();
    chk("mask_idle", 32'(state_o), 0);

    coin();
    idle(4);
    vend_req = 1'b1;
    cyc();
    vend_req = 1'b0;
    idle(2);
    chk("rd_motor_on", 32'(motor_on), 1);
    rst = 1'b1;
    #1;
    chk("rd_motor_drop", 32'(motor_on), 0);
    chk("rd_state", 32'(state_o), 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("rd_post_state", 32'(state_o), 0);
    chk("rd_post_tgen", 32'(tg_en), 0);

`ifdef VEND_TIMER_TIMEOUT_CNT_EN
    chk("tc_reset", 32'(timeout_cnt), 0);
    for (int i = 0; i < 257; i++) begin
      timeout_seq();
      half_rise();
      half_rise();
      if (i == 0)
        chk("tc_first", 32'(timeout_cnt), 1);
    end
    chk("tc_sat", 32'(timeout_cnt), 255);
    timeout_seq();
    chk("gd_refund", 32'(state_o), 4);
    sec_rise();
    sec_rise();
    chk("gd_hold", 32'(state_o), 4);
    sec_rise();
    chk("gd_exit", 32'(state_o), 0);
    chk("tc_still_sat", 32'(timeout_cnt), 255);
`endif

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
